// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  // One reservation slot: the PC is known at issue, the instruction arrives later.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            filled;
  } fetch_entry_t;

  // Clear the byte-offset bits of a fetch address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Reservation FIFO: slots are allocated in issue order, filled in response order
// and popped in program order. Flush drops every slot at once.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc,
  input  logic [XLEN-1:0]      alloc_pc,
  input  logic                 fill,
  input  logic [XLEN-1:0]      fill_inst,
  input  logic                 pop,
  output fetch_entry_t         head_entry,
  output logic [CW-1:0]        count,
  output logic [CW-1:0]        unfilled
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q, fill_q;
  logic [CW-1:0] count_q, unfilled_q;
  logic          head_valid, alloc_en, fill_en, pop_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_valid = (count_q != '0) && mem_q[head_q].filled;
  // Guards keep a misbehaving producer from corrupting the pointers.
  assign alloc_en   = alloc && (count_q != CW'(DEPTH));
  assign fill_en    = fill && (unfilled_q != '0);
  assign pop_en     = pop && head_valid;

  assign head_entry = mem_q[head_q];
  assign count      = count_q;
  assign unfilled   = unfilled_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      if (alloc_en) tail_q <= ptr_inc(tail_q);
      if (fill_en)  fill_q <= ptr_inc(fill_q);
      if (pop_en)   head_q <= ptr_inc(head_q);
      count_q    <= count_q + CW'(alloc_en) - CW'(pop_en);
      unfilled_q <= unfilled_q + CW'(alloc_en) - CW'(fill_en);
    end
  end

  // Slot storage; contents are only meaningful while count covers the slot.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      mem_q[tail_q] <= '{pc: alloc_pc, inst: '0, filled: 1'b0};
    end
    if (fill_en) begin
      mem_q[fill_q].inst   <= fill_inst;
      mem_q[fill_q].filled <= 1'b1;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, request issue, stale-response drop counter and
// the decode-side valid/ready interface in front of the reservation FIFO.
module ifetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count, unfilled, owed;
  logic [CW:0]     occupancy;
  logic            accept, fill, pop;
  fetch_entry_t    head_entry;

  // Stale responses still occupy a slot's worth of memory capacity.
  assign occupancy = {1'b0, count} + {1'b0, drop_cnt_q};
  assign imem_req  = !rst && !redirect_valid && (occupancy < (CW + 1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;

  assign fill      = imem_rvalid && (drop_cnt_q == '0) && !redirect_valid;
  assign id_valid  = (count != '0) && head_entry.filled && !redirect_valid;
  assign pop       = id_valid && id_ready;
  assign id_inst   = head_entry.inst;
  assign id_pc     = head_entry.pc;

  assign owed      = drop_cnt_q + unfilled;

  // Next fetch PC and number of responses to throw away.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      // Every unfilled slot becomes owed; a response this cycle pays one off.
      drop_cnt_d = owed - CW'(imem_rvalid && (owed != '0));
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
      if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  // PC and drop counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .alloc      (accept),
    .alloc_pc   (fetch_pc_q),
    .fill       (fill),
    .fill_inst  (imem_rdata),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count),
    .unfilled   (unfilled)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: an in-order memory with random latency and stalls,
// plus an epoch-based model of what the fetch stage must present each cycle.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_ready, imem_rvalid, redirect_valid, id_valid, id_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, id_inst, id_pc;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pend[$];
  int          epoch = 0, ready_cnt = 0, cyc = 0, checks = 0, errors = 0;
  logic [31:0] exp_fetch = RESET_PC, exp_dec = RESET_PC;

  // Stimulus knobs for the next cycle.
  logic        d_rst = 1'b1, d_redir = 1'b0;
  logic [31:0] d_rpc = '0;
  int          p_ready = 100, p_id_ready = 100, lat_min = 1, lat_max = 1;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check the model, advance the model.
  task automatic step();
    int   cur, stale;
    logic exp_req, exp_valid;
    req_t r;
    @(negedge clk);
    rst            = d_rst;
    redirect_valid = d_redir;
    redirect_pc    = d_rpc;
    imem_ready     = ($urandom_range(99) < p_ready);
    id_ready       = ($urandom_range(99) < p_id_ready);
    imem_rvalid    = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rdata     = imem_rvalid ? memfn(pend[0].addr) : $urandom;
    #1;
    if (rst) begin
      check("req_in_reset", {31'b0, imem_req}, 32'd0);
      pend.delete();
      epoch++;
      ready_cnt = 0;
      exp_fetch = RESET_PC;
      exp_dec   = RESET_PC;
    end else begin
      cur = 0;
      foreach (pend[i]) if (pend[i].epoch == epoch) cur++;
      stale     = pend.size() - cur;
      exp_req   = !redirect_valid && (cur + ready_cnt + stale < DEPTH);
      exp_valid = (ready_cnt > 0) && !redirect_valid;
      check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      check("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
      if (exp_req && imem_req) check("imem_addr", imem_addr, exp_fetch);
      if (exp_valid && id_valid) begin
        check("id_pc", id_pc, exp_dec);
        check("id_inst", id_inst, memfn(exp_dec));
      end
      if (imem_rvalid) begin
        r = pend.pop_front();
        if (r.epoch == epoch && !redirect_valid) ready_cnt++;
      end
      if (redirect_valid) begin
        epoch++;
        ready_cnt = 0;
        exp_fetch = {redirect_pc[31:2], 2'b00};
        exp_dec   = exp_fetch;
      end else begin
        if (exp_req && imem_ready) begin
          pend.push_back('{addr: exp_fetch, epoch: epoch,
                           due: cyc + $urandom_range(lat_max, lat_min)});
          exp_fetch += 32'd4;
        end
        if (exp_valid && id_ready) begin
          ready_cnt--;
          exp_dec += 32'd4;
        end
      end
    end
    cyc++;
  endtask

  initial begin
    bit seen;
    rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

    // Reset, then streaming with an ideal 1-cycle memory and ready decode.
    repeat (3) step();
    d_rst = 1'b0;
    step();
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RESET_PC);
    check("reset_id_valid", {31'b0, id_valid}, 32'd0);
    step();
    check("second_addr", imem_addr, RESET_PC + 32'd4);
    step();
    check("first_valid", {31'b0, id_valid}, 32'd1);
    check("first_pc", id_pc, RESET_PC);
    step();
    check("second_pc", id_pc, RESET_PC + 32'd4);
    repeat (6) step();

    // Decode stalls: FIFO fills and requests stop.
    p_id_ready = 0;
    repeat (10) step();
    check("stall_req_low", {31'b0, imem_req}, 32'd0);
    check("stall_valid", {31'b0, id_valid}, 32'd1);
    p_id_ready = 100;
    repeat (12) step();

    // Redirect with fetches in flight.
    lat_min = 2; lat_max = 2;
    repeat (5) step();
    d_redir = 1'b1; d_rpc = 32'h100;
    step();
    d_redir = 1'b0;
    step();
    check("redir_req", {31'b0, imem_req}, 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (id_valid) begin
        seen = 1'b1;
        check("redir_first_pc", id_pc, 32'h100);
      end
    end
    if (!seen) check("redir_timeout", 32'd0, 32'd1);

    // Redirect coinciding with a response and a decode handshake.
    lat_min = 1; lat_max = 1;
    repeat (6) step();
    d_redir = 1'b1; d_rpc = 32'h40;
    step();
    check("redir_rvalid_present", {31'b0, imem_rvalid}, 32'd1);
    check("redir_blocks_valid", {31'b0, id_valid}, 32'd0);
    d_redir = 1'b0;
    repeat (6) step();

    // Misaligned redirect target.
    d_redir = 1'b1; d_rpc = 32'h103;
    step();
    d_redir = 1'b0;
    step();
    check("align_addr", imem_addr, 32'h100);
    repeat (4) step();

    // PC wraps past the top of the address space.
    d_redir = 1'b1; d_rpc = 32'hFFFF_FFF8;
    step();
    d_redir = 1'b0;
    repeat (10) step();

    // Random stalls, latencies, redirects and resets.
    p_ready = 70; p_id_ready = 70; lat_min = 1; lat_max = 5;
    for (int i = 0; i < 3000; i++) begin
      d_redir = ($urandom_range(99) < 4);
      d_rpc   = $urandom & 32'h0000_FFFF;
      d_rst   = ($urandom_range(999) < 5);
      step();
    end
    d_redir = 1'b0; d_rst = 1'b0;
    repeat (5) step();

    // Reset pulsed mid-stream.
    d_rst = 1'b1;
    step();
    d_rst = 1'b0;
    step();
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_req", {31'b0, imem_req}, 32'd1);
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage: owns the PC, issues word fetches to instruction memory over a req/ready request channel with in-order rvalid responses, and buffers returned instructions tagged with their PC in a small reservation FIFO. Feeds the decode stage, whose opcode field drives the control unit, through a valid/ready handshake. Accepts a redirect from execute on taken branch, JAL or JALR, and discards all stale in-flight fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 4, FIFO slots; must be ≥3 for 1 inst/cycle with 1-cycle memory.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  32  word-aligned fetch address
- imem_ready  in  1  request accepted when imem_req && imem_ready
- imem_rvalid  in  1  response valid; responses return in request order, ≥1 cycle after acceptance
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  taken branch/JAL/JALR from execute
- redirect_pc  in  32  new fetch PC; bits [1:0] forced to 0
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode accepts; transfer on id_valid && id_ready
- id_inst  out  32  instruction word
- id_pc  out  32  PC of id_inst

## Operation
- State: fetch_pc, FIFO of {pc, inst, filled}, count (allocated slots), drop_cnt (stale responses still owed).
- Issue: imem_req = !rst && !redirect_valid && (count + drop_cnt < DEPTH); imem_addr = fetch_pc. On acceptance, allocate a tail slot with pc = fetch_pc and filled = 0; fetch_pc += 4, wrapping mod 2^32.
- Response: if drop_cnt > 0, discard and decrement drop_cnt. Otherwise write imem_rdata into the oldest unfilled slot and set filled.
- Output: id_valid = head slot filled && !redirect_valid; id_inst and id_pc come from the head slot. Head pops on a handshake.
- Redirect: flush the FIFO (count = 0); fetch_pc = redirect_pc & ~3.
  - drop_cnt_next = drop_cnt + unfilled_slots − (imem_rvalid ? 1 : 0). A response in the redirect cycle is stale by definition.
  - An unaccepted request in that cycle is withdrawn; no allocation occurs.
- Simultaneous events:
  - redirect plus pop: redirect wins and the pop is ignored.
  - issue plus response plus pop in the same cycle: all three apply.
  - Full FIFO (count + drop_cnt == DEPTH): imem_req low.
  - Empty FIFO: id_valid low.
- id_inst and id_pc hold stable while id_valid && !id_ready.

## Timing
- Reset values: imem_req 0, id_valid 0, fetch_pc RESET_PC, count 0, drop_cnt 0. imem_addr and id_* outputs are don't-care while invalid.
- First cycle after rst falls: imem_req = 1, imem_addr = RESET_PC.
- Latency: request accepted in cycle t with response at t+L gives id_valid at t+L+1.
- Redirect in cycle t: first request to redirect_pc in cycle t+1.
- Slot lifetime is 3 cycles at L=1. DEPTH=4 sustains one fetch per cycle with a ready decode.
- rst asserted mid-operation discards all state in one cycle, including drop_cnt. Memory must abandon outstanding responses on the same rst.

## Structure
- fetch_pkg: fetch_entry_t struct {pc, inst, filled}, XLEN = 32, INST_BYTES = 4.
- One sub-module, fetch_fifo: reservation FIFO with alloc/fill/pop/flush, head/tail/fill pointers and count. ifetch_unit holds the PC, issue logic and drop counter.

## Test plan
- Reset, memory always ready, L=1, decode always ready → addresses 0, 4, 8… issued every cycle; id_pc 0 first appears 2 cycles after the first request; one instruction per cycle thereafter.
- id_ready held low for 10 cycles → 4 slots fill, imem_req drops, id_inst/id_pc stable; on release, in-order drain with no loss or duplication.
- Redirect to 0x100 while 2 fetches are in flight → both returning responses discarded; next request addr 0x100; first id_pc = 0x100.
- Redirect in the same cycle as imem_rvalid and an id handshake → that response is dropped, drop_cnt = remaining unfilled slots, id_valid low that cycle.
- Random imem_ready stalls and L=1..5 → id_pc sequence matches a reference model exactly; count + drop_cnt never exceeds DEPTH.
- Redirect to 0x103 → fetch at 0x100. rst pulsed mid-stream → next cycle imem_addr = RESET_PC and id_valid = 0.
